// File: rtl/sr_ctrl.sv
// Status-register controller: arbitrates irq/reti/write/ALU updates onto SRSet,
// keeps a shadow stack for nested interrupts and cross-checks the SRData readback.
module sr_ctrl #(
  parameter logic [7:0] SR_RESET  = 8'h00,
  parameter int         IE_BIT    = 7,
  parameter int         STK_DEPTH = 4,
  parameter int         DEPTH_W   = 4,
  parameter int         RD_LAT    = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               irq_valid,
  output logic               irq_ack,
  input  logic               reti_valid,
  output logic               reti_ack,
  input  logic               wr_valid,
  input  logic [7:0]         wr_data,
  output logic               wr_ack,
  input  logic               alu_valid,
  input  logic [7:0]         alu_mask,
  input  logic [7:0]         alu_flags,
  output logic               alu_ack,
  input  logic [7:0]         sr_data,
  output logic [7:0]         sr_set,
  output logic [DEPTH_W-1:0] depth,
  output logic               stk_ovf,
  output logic               stk_unf,
  output logic               chk_err
);

  localparam int               WARM_W  = 3;
  localparam logic [WARM_W-1:0] WARM_N = WARM_W'(RD_LAT + 1);
  localparam logic [7:0]       IE_MASK = 8'h01 << IE_BIT;

  logic [7:0]         sr_q, sr_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               chk_q, chk_d;
  logic [7:0]         shadow_q [STK_DEPTH];
  logic [7:0]         shadow_d [STK_DEPTH];
  logic [7:0]         exp_q [RD_LAT];
  logic [7:0]         exp_d [RD_LAT];
  logic [WARM_W-1:0]  warm_q, warm_d;

  logic       ie, full, empty, irq_ok;
  logic [7:0] sh_top;

  always_comb begin
    ie       = sr_q[IE_BIT];
    full     = (depth_q == DEPTH_W'(STK_DEPTH));
    empty    = (depth_q == '0);
    irq_ok   = irq_valid & ie & ~full;
    irq_ack  = irq_ok;
    reti_ack = reti_valid & ~irq_ok;
    wr_ack   = wr_valid & ~irq_ok & ~reti_valid;
    alu_ack  = alu_valid & ~irq_ok & ~reti_valid & ~wr_valid;
  end

  // Most recently pushed entry; explicit mux keeps index widths clean.
  always_comb begin
    sh_top = 8'h00;
    for (int i = 0; i < STK_DEPTH; i++) begin
      if (depth_q == DEPTH_W'(i + 1)) sh_top = shadow_q[i];
    end
  end

  always_comb begin
    sr_d     = sr_q;
    depth_d  = depth_q;
    shadow_d = shadow_q;
    ovf_d    = ovf_q | (irq_valid & ie & full);
    unf_d    = unf_q | (reti_ack & empty);
    if (irq_ack) begin
      for (int i = 0; i < STK_DEPTH; i++) begin
        if (depth_q == DEPTH_W'(i)) shadow_d[i] = sr_q;
      end
      depth_d = depth_q + DEPTH_W'(1);
      sr_d    = sr_q & ~IE_MASK;
    end else if (reti_ack) begin
      if (!empty) begin
        sr_d    = sh_top;
        depth_d = depth_q - DEPTH_W'(1);
      end
    end else if (wr_ack) begin
      sr_d = wr_data;
    end else if (alu_ack) begin
      sr_d = (sr_q & ~alu_mask) | (alu_flags & alu_mask);
    end
  end

  // The SR block is unreset, so its readback is ignored until the pipeline has filled.
  always_comb begin
    exp_d    = exp_q;
    exp_d[0] = sr_q;
    for (int i = 1; i < RD_LAT; i++) exp_d[i] = exp_q[i-1];
    warm_d = (warm_q == WARM_N) ? warm_q : warm_q + WARM_W'(1);
    chk_d  = chk_q | ((warm_q == WARM_N) && (sr_data != exp_q[RD_LAT-1]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q    <= SR_RESET;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      chk_q   <= 1'b0;
      warm_q  <= '0;
      for (int i = 0; i < STK_DEPTH; i++) shadow_q[i] <= 8'h00;
      for (int i = 0; i < RD_LAT; i++) exp_q[i] <= SR_RESET;
    end else begin
      sr_q     <= sr_d;
      depth_q  <= depth_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      chk_q    <= chk_d;
      warm_q   <= warm_d;
      shadow_q <= shadow_d;
      exp_q    <= exp_d;
    end
  end

  assign sr_set  = sr_q;
  assign depth   = depth_q;
  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;
  assign chk_err = chk_q;

endmodule

// File: doc/sr_ctrl.md
Name: sr_ctrl

Overview:
Owns the architectural value of the CPU status register (SR) and drives the SR block's SRSet input every cycle.
Arbitrates four update sources onto the single SR write path: interrupt entry, interrupt return, explicit SR write and ALU flag update.
Keeps a shadow stack of saved SR values for nested interrupts.
Checks that the SR block's delayed readback (SRData) matches what was driven.

Parameters:
SR_RESET, 8'h00, SR value loaded on reset
IE_BIT, 7, bit index of the interrupt-enable flag inside SR
STK_DEPTH, 4, shadow stack entries (1..8)
DEPTH_W, 4, width of depth output; must hold values 0..STK_DEPTH
RD_LAT, 1, clock edges from sr_set change to matching sr_data (1..3)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
irq_valid  in  1  interrupt-entry request; held until irq_ack
irq_ack  out  1  irq request accepted this cycle
reti_valid  in  1  return-from-interrupt request; held until reti_ack
reti_ack  out  1  reti request accepted this cycle
wr_valid  in  1  explicit SR write request; held until wr_ack
wr_data  in  8  value for explicit write
wr_ack  out  1  write accepted this cycle
alu_valid  in  1  ALU flag update request; held until alu_ack
alu_mask  in  8  SR bits the ALU updates
alu_flags  in  8  new values for the masked bits
alu_ack  out  1  ALU update accepted this cycle
sr_data  in  8  SRData readback from the SR block
sr_set  out  8  registered; drives SRSet of the SR block; equals the architectural SR
depth  out  DEPTH_W  shadow stack occupancy
stk_ovf  out  1  sticky: interrupt blocked because the stack was full
stk_unf  out  1  sticky: reti issued with an empty stack
chk_err  out  1  sticky: sr_data disagreed with expected delayed sr_set

Behaviour:
- Reset (asynchronous, rst_n=0):
  - sr_set=SR_RESET, depth=0.
  - stk_ovf, stk_unf and chk_err = 0.
  - All shadow entries = 0; the expected-value pipeline = SR_RESET.
  - The checker warm-up counter is cleared.
- Acks are combinational from the current state and inputs. At most one ack is high per cycle.
- The state update happens on the rising edge where the ack is high. A requester that is not acked must hold its request; it stays pending with no loss.
- Eligibility:
  - irq is eligible only when sr_set[IE_BIT]=1 and depth<STK_DEPTH.
  - reti, wr and alu are always eligible.
- Fixed priority among eligible valids: irq > reti > wr > alu.
- irq (acked): push sr_set to shadow[depth]; depth+1; sr_set <= sr_set with IE_BIT cleared, all other bits unchanged.
- irq_valid with IE=1 and depth==STK_DEPTH: no ack, stk_ovf<=1, and arbitration falls through to the next source.
- irq_valid with IE=0: no ack, no flag set (interrupt masked).
- reti (acked), depth>0: sr_set <= shadow[depth-1]; depth-1.
- reti (acked), depth==0: sr_set unchanged; stk_unf<=1. The ack is still given so the sequencer never stalls.
- wr (acked): sr_set <= wr_data.
- alu (acked): sr_set <= (sr_set & ~alu_mask) | (alu_flags & alu_mask). alu_mask=0 is acked and is a no-op.
- No request accepted: sr_set holds. SRSet is driven continuously, so the SR block re-captures the same value.
- Checker:
  - exp pipeline of RD_LAT stages, fed by sr_set every edge.
  - Comparison is enabled only after RD_LAT+1 edges have elapsed since reset release, because the SR block has no reset and its output is unknown until then.
  - When enabled, sr_data != exp[RD_LAT-1] on an edge sets chk_err<=1.
- Sticky flags clear only on reset.
- Shadow entries above depth are stale and never read.

Test Plan:
- Reset, then idle 5 cycles -> sr_set=8'h00, depth=0, all acks 0, chk_err=0 with SR connected.
- wr_valid with wr_data=8'h81, then alu_valid with mask=8'h0F, flags=8'h05 -> sr_set 8'h81, then 8'h85; sr_data follows one cycle later; chk_err=0.
- From sr_set=8'h85, assert irq, wr and alu together -> irq_ack only; sr_set=8'h05, depth=1. Next cycle wr_ack, then alu_ack in the following cycle.
- Set SR=8'h80 and take STK_DEPTH nested irqs, writing 8'h80 back between them -> depth=4. Next irq: no ack, stk_ovf=1, a pending wr is acked in the same cycle.
- Issue reti 4 times -> sr_set restores the saved values in LIFO order and depth reaches 0. A 5th reti is acked with sr_set unchanged and stk_unf=1.
- Force sr_data=8'hFF while sr_set=8'h00 after warm-up -> chk_err=1 and stays 1. Assert rst_n=0 mid-irq -> all outputs return to their reset values immediately.
